// File: rtl/hier_node_bcast.sv
// Hierarchy node: broadcasts one command to the enabled child slots, XOR-merges
// one response per child and returns a single combined response upstream.
module hier_node_bcast #(
   parameter int NUM_CHILD = 10,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [DATA_W-1:0]           cmd_data,
   input  logic [NUM_CHILD-1:0]        en_mask,
   output logic [NUM_CHILD-1:0]        ch_valid,
   output logic [DATA_W-1:0]           ch_data,
   input  logic [NUM_CHILD-1:0]        ch_ready,
   input  logic [NUM_CHILD-1:0]        rsp_in_valid,
   input  logic [NUM_CHILD*DATA_W-1:0] rsp_in_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [NUM_CHILD-1:0]        rsp_mask,
   output logic                        rsp_timeout
);

   // A zero TIMEOUT still needs a legal one-bit counter.
   localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TMO_W-1:0] TMO_SAT  = {TMO_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [DATA_W-1:0]     r_ch_data;
   logic [NUM_CHILD-1:0]  r_issue_pend;
   logic [NUM_CHILD-1:0]  r_resp_pend;
   logic [DATA_W-1:0]     r_acc;
   logic [NUM_CHILD-1:0]  r_got_mask;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic                  r_timeout;

   logic                  w_active;
   logic [NUM_CHILD-1:0]  w_ch_valid;
   logic [NUM_CHILD-1:0]  w_issue_hs;
   logic [NUM_CHILD-1:0]  w_cap;
   logic [NUM_CHILD-1:0]  w_issue_left;
   logic [NUM_CHILD-1:0]  w_resp_left;
   logic [DATA_W-1:0]     w_slice [NUM_CHILD];
   logic [DATA_W-1:0]     w_cap_xor;
   logic                  w_done;
   logic                  w_tmo_hit;

   assign w_active     = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign w_ch_valid   = (r_state == S_ISSUE) ? r_issue_pend : '0;
   assign w_issue_hs   = w_ch_valid & ch_ready;
   assign w_cap        = w_active ? (rsp_in_valid & r_resp_pend) : '0;
   assign w_issue_left = r_issue_pend & ~w_issue_hs;
   assign w_resp_left  = r_resp_pend & ~w_cap;
   assign w_done       = (w_issue_left == '0) && (w_resp_left == '0);
   assign w_tmo_hit    = (TIMEOUT != 0) && w_active && (r_tmo_cnt == TMO_LAST) && !w_done;

   // Each captured child contributes its slice; non-captured slices are zero.
   generate
      for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_slice
         assign w_slice[gi] = w_cap[gi] ? rsp_in_data[gi*DATA_W +: DATA_W] : '0;
      end
   endgenerate

   always_comb begin
      w_cap_xor = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         w_cap_xor = w_cap_xor ^ w_slice[i];
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_state_next = (en_mask == '0) ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_done || w_tmo_hit) begin
               w_state_next = S_RESP;
            end else if (w_issue_left == '0) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_done || w_tmo_hit) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch_data    <= '0;
         r_issue_pend <= '0;
         r_resp_pend  <= '0;
         r_acc        <= '0;
         r_got_mask   <= '0;
         r_tmo_cnt    <= '0;
         r_timeout    <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (cmd_valid) begin
            r_ch_data    <= cmd_data;
            r_issue_pend <= en_mask;
            r_resp_pend  <= en_mask;
            r_acc        <= '0;
            r_got_mask   <= '0;
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
         end
      end else if (w_active) begin
         // Captures in the abort cycle still land; outstanding bookkeeping is dropped.
         r_issue_pend <= w_tmo_hit ? '0 : w_issue_left;
         r_resp_pend  <= w_tmo_hit ? '0 : w_resp_left;
         r_acc        <= r_acc ^ w_cap_xor;
         r_got_mask   <= r_got_mask | w_cap;
         r_timeout    <= w_tmo_hit;
         if (r_tmo_cnt != TMO_SAT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign ch_valid    = w_ch_valid;
   assign ch_data     = r_ch_data;
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_data    = r_acc;
   assign rsp_mask    = r_got_mask;
   assign rsp_timeout = r_timeout;

endmodule

// File: doc/hier_node_bcast.md
# hier_node_bcast

Parametrised hierarchy node that accepts one command, broadcasts it to up to NUM_CHILD child instances, collects one response from each enabled child, and returns a single combined response upstream. It replaces fixed, portless per-level wrapper modules with a generic node. Nodes can be nested to any depth: each node's upstream port connects to one child slot of its parent. Each node adds per-child masking, XOR result merging, and a bounded-wait timeout.

## Interface
Parameters:
- NUM_CHILD, 10, number of child slots (1..32)
- DATA_W, 32, command/response data width
- TIMEOUT, 255, cycles allowed in ISSUE+WAIT before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  node is idle and can accept a command
- cmd_data  in  DATA_W  command payload
- en_mask  in  NUM_CHILD  children that take part; sampled only on command accept
- ch_valid  out  NUM_CHILD  per-child command valid
- ch_data  out  DATA_W  broadcast payload, shared by all children
- ch_ready  in  NUM_CHILD  per-child command accept
- rsp_in_valid  in  NUM_CHILD  per-child response strobe, one cycle per response
- rsp_in_data  in  NUM_CHILD*DATA_W  child i occupies bits [i*DATA_W +: DATA_W]
- rsp_valid  out  1  combined response valid
- rsp_ready  in  1  upstream response accept
- rsp_data  out  DATA_W  XOR of all received child responses
- rsp_mask  out  NUM_CHILD  children whose response was received
- rsp_timeout  out  1  response was produced by timeout abort

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_data into ch_data; set issue_pend=en_mask and resp_pend=en_mask; clear acc, got_mask, tmo_cnt.
  - If en_mask==0, go to RESP with rsp_data=0, rsp_mask=0, rsp_timeout=0. Otherwise go to ISSUE.
- ISSUE:
  - ch_valid=issue_pend.
  - A bit of issue_pend clears in any cycle where ch_valid[i]&ch_ready[i].
  - When issue_pend becomes 0 (after this cycle's clears), go to WAIT.
- Response capture (ISSUE and WAIT):
  - A response from child i is counted when rsp_in_valid[i] & resp_pend[i].
  - On capture: acc ^= slice i; got_mask[i]=1; resp_pend[i]=0.
  - Multiple children may respond in the same cycle; all are XORed that cycle.
  - rsp_in_valid for a non-pending child is ignored.
  - A child may respond in the same cycle its command is accepted.
- WAIT: ch_valid=0. When resp_pend becomes 0 and issue_pend==0, go to RESP.
- Timeout:
  - tmo_cnt increments every cycle in ISSUE or WAIT.
  - If TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 while the node is not completing that cycle: go to RESP with rsp_timeout=1. Responses captured in that same cycle are still included.
  - Remaining issue_pend bits are dropped. ch_valid goes to 0 on the next cycle.
- RESP:
  - rsp_valid=1; rsp_data=acc, rsp_mask=got_mask, rsp_timeout are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_in_valid is ignored.
- Widths: tmo_cnt is clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Timing
- Reset values: state=IDLE, cmd_ready=1, ch_valid=0, ch_data=0, rsp_valid=0, rsp_data=0, rsp_mask=0, rsp_timeout=0.
- All outputs are registered or driven from state only; there is no combinational path from any input to any output.
- Minimum latency, with the command accepted at cycle T:
  - ch_valid asserts at T+1.
  - If every child asserts ch_ready and rsp_in_valid at T+1, rsp_valid asserts at T+2.
- Empty mask: accept at T, rsp_valid at T+1.
- Back-to-back: after the rsp_valid&rsp_ready cycle, cmd_ready=1 on the next cycle. Throughput is at most one command per 3 cycles.
- Timeout: with all children silent and TIMEOUT=N, rsp_valid asserts exactly N+1 cycles after the accept cycle.
- Reset mid-operation: any state returns to IDLE on the next edge. Pending issue and response bookkeeping is discarded and no response is produced.

## Test plan
- NUM_CHILD=10, en_mask=0x3FF, all children ready immediately and respond at T+1 with data i+1 -> rsp_valid at T+2, rsp_data=0x0B, rsp_mask=0x3FF, rsp_timeout=0.
- en_mask=0x005; child 2 holds ch_ready low for 4 cycles; child 0 responds 0xA5 and child 2 responds 0x5A; a spurious rsp_in_valid[1] is driven -> rsp_data=0xFF, rsp_mask=0x005, ch_valid[1] never asserts.
- TIMEOUT=8, en_mask=0x3FF, only children 0..4 respond -> rsp_valid at T+9, rsp_timeout=1, rsp_mask=0x01F, ch_valid=0 from T+9.
- en_mask=0 -> rsp_valid at T+1, rsp_data=0, rsp_mask=0; rsp_ready held low 5 cycles -> outputs stable and cmd_ready=0 throughout.
- rst pulsed in WAIT with 3 responses pending -> next cycle cmd_ready=1, rsp_valid=0, ch_valid=0; a new command then completes normally.
- Two nested nodes (root NUM_CHILD=2, leaves NUM_CHILD=3, leaf children echo their index) -> root rsp_data=XOR of all six leaf values, rsp_mask=0x3.
